// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Round-robin arbiter that shares the single push port of a DEPTH-entry
//   FIFO among N requesters. It also owns the FIFO occupancy counter and
//   produces full/empty/count for the FIFO storage.
//   Grant is combinational (zero latency): a requester sees its grant
//   in the same cycle and its data is written at the following posedge.
//   Optional feature: define ARB_SVA_EN to compile embedded assertions.
module fifo_push_arbiter #(
    parameter int N     = 4,
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               req,
    input  logic [N*WIDTH-1:0]         req_data,
    output logic [N-1:0]               grant,
    output logic                       push,
    output logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic                       pop_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic          r_pop_err;

    logic [PW-1:0] w_winner;
    logic          w_found;
    logic          w_grant_en;
    logic          w_pop_eff;
    logic [PW-1:0] w_ptr_next;

    // Search req starting at the round-robin pointer for the first active requester
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % N;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = PW'(idx);
            end else begin
                w_found  = w_found;
                w_winner = w_winner;
            end
        end
    end

    assign full       = (r_count == CW'(DEPTH));
    assign empty      = (r_count == {CW{1'b0}});
    assign count      = r_count;
    assign pop_err    = r_pop_err;

    // Grant is suppressed while in reset or while the FIFO has no room
    assign w_grant_en = w_found && !full && rst_n;
    assign w_pop_eff  = pop && !empty;

    // Drive the one-hot grant, push strobe and winner's data word
    always_comb begin
        if (w_grant_en) begin
            grant   = {{(N-1){1'b0}}, 1'b1} << w_winner;
            push    = 1'b1;
            data_in = req_data[int'(w_winner)*WIDTH +: WIDTH];
        end else begin
            grant   = {N{1'b0}};
            push    = 1'b0;
            data_in = {WIDTH{1'b0}};
        end
    end

    // Pointer moves to the slot after the winner, wrapping N-1 to 0
    always_comb begin
        if (w_winner == PW'(N - 1)) begin
            w_ptr_next = {PW{1'b0}};
        end else begin
            w_ptr_next = w_winner + PW'(1);
        end
    end

    // Round-robin pointer, occupancy counter and pop-error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= {PW{1'b0}};
            r_count   <= {CW{1'b0}};
            r_pop_err <= 1'b0;
        end else begin
            if (push) begin
                r_ptr <= w_ptr_next;
            end else begin
                r_ptr <= r_ptr;
            end
            case ({push, w_pop_eff})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_pop_err <= pop && empty;
        end
    end

`ifdef ARB_SVA_EN
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant)) else $error("grant not onehot0");
    a_grant_subset: assert property (@(posedge clk) disable iff (!rst_n)
        (grant & ~req) == {N{1'b0}}) else $error("grant without req");
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        full |-> !push) else $error("push while full");
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CW'(DEPTH)) else $error("count above DEPTH");
    a_empty_flag: assert property (@(posedge clk) disable iff (!rst_n)
        (r_count == {CW{1'b0}}) == empty) else $error("empty flag wrong");
    a_full_flag: assert property (@(posedge clk) disable iff (!rst_n)
        (r_count == CW'(DEPTH)) == full) else $error("full flag wrong");
    a_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !$isunknown(data_in)) else $error("data_in unknown on push");
`else
    // Assertions compiled out; behaviour is identical.
`endif

endmodule
